// File: rtl/weight_loader_pkg.sv
// Shared defines and types for the weight loader: array geometry macros, FSM encoding, row-counter width.
// Optional feature macro used by the top: WEIGHT_LOADER_ZPAD_EN.
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef DATASIZE
`define DATASIZE 8
`endif

package weight_loader_pkg;
  localparam int unsigned N      = `ARRAYWIDTH;
  localparam int unsigned DW     = `DATASIZE;
  localparam int unsigned DATA_W = N * DW;
  localparam int unsigned ROW_W  = $clog2(N) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_READY = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Zero or over-range row counts mean a full tile.
  function automatic logic [ROW_W-1:0] eff_rows(input logic [ROW_W-1:0] r);
    return (r == '0 || r > ROW_W'(N)) ? ROW_W'(N) : r;
  endfunction
endpackage

// File: rtl/weight_loader_ctr.sv
// Row counter shared by the fetch and drain phases; last flags the N-th counted cycle.
module weight_loader_ctr
  import weight_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [ROW_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (inc)   count <= count + 1'b1;
  end

  assign last = (count == ROW_W'(N - 1));

endmodule

// File: rtl/weight_loader.sv
// Streams one N-row weight tile from SRAM into the weight buffer, then shifts it out on drain_req.
// Define WEIGHT_LOADER_ZPAD_EN to read only num_rows rows and zero-pad the rest.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ROW_W-1:0]  num_rows,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_load_en,
  output logic [DATA_W-1:0] wb_in_weight,
  output logic              wb_out_en,
  input  logic              drain_req,
  output logic              weights_ready,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic              issue;
  logic              data_vld;
  logic [ADDR_W-1:0] base_q;
  logic [ROW_W-1:0]  count;
  logic              last;
  logic              ctr_clr;
  logic              ctr_inc;
  logic              next_real;

  assign ctr_clr = (state == S_IDLE && start) || (state == S_READY && drain_req);
  assign ctr_inc = issue || wb_out_en;

  weight_loader_ctr u_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (ctr_clr),
    .inc  (ctr_inc),
    .count(count),
    .last (last)
  );

`ifdef WEIGHT_LOADER_ZPAD_EN
  logic [ROW_W-1:0] rows_q;

  always_ff @(posedge clk) begin
    if (rst)                         rows_q <= '0;
    else if (state == S_IDLE && start) rows_q <= eff_rows(num_rows);
  end

  assign next_real = (ROW_W'(count + 1'b1) < rows_q);
`else
  logic unused_rows;
  assign unused_rows = ^num_rows;
  assign next_real   = 1'b1;
`endif

  // Read data is passed straight through; pad rows and idle cycles present zero.
  assign wb_in_weight = (wb_load_en && data_vld) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      issue         <= 1'b0;
      data_vld      <= 1'b0;
      base_q        <= '0;
      mem_rd_en     <= 1'b0;
      mem_addr      <= '0;
      wb_load_en    <= 1'b0;
      wb_out_en     <= 1'b0;
      weights_ready <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      data_vld   <= mem_rd_en;
      wb_load_en <= issue;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            busy      <= 1'b1;
            issue     <= 1'b1;
            base_q    <= base_addr;
            mem_rd_en <= 1'b1;
            mem_addr  <= base_addr;
          end
        end
        S_FETCH: begin
          if (issue) begin
            if (last) begin
              issue     <= 1'b0;
              mem_rd_en <= 1'b0;
              mem_addr  <= '0;
            end else begin
              mem_rd_en <= next_real;
              mem_addr  <= next_real ? base_q + ADDR_W'(count + 1'b1) : '0;
            end
          end else if (wb_load_en) begin
            state         <= S_READY;
            weights_ready <= 1'b1;
          end
        end
        S_READY: begin
          if (drain_req) begin
            state         <= S_DRAIN;
            weights_ready <= 1'b0;
            wb_out_en     <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (last) begin
            state     <= S_DONE;
            wb_out_en <= 1'b0;
            done      <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader (N=4, DATASIZE=8, ADDR_W=10) with a one-cycle-latency SRAM model.
module tb_weight_loader;

  typedef struct packed {
    logic        rd;
    logic [9:0]  addr;
    logic        load;
    logic [31:0] wdata;
    logic        ready;
    logic        out;
    logic        done;
    logic        busy;
  } obs_t;

  localparam int NCYC = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [2:0]  num_rows = 3'd4;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        wb_load_en;
  logic [31:0] wb_in_weight;
  logic        wb_out_en;
  logic        drain_req = 1'b0;
  logic        weights_ready;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:1023];
  obs_t        cap [0:NCYC-1];
  logic        st_start [0:NCYC-1];
  logic        st_drain [0:NCYC-1];
  logic        st_rst   [0:NCYC-1];
  int          n_checks = 0;
  int          n_fail = 0;

  weight_loader #(.ADDR_W(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .num_rows     (num_rows),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .wb_load_en   (wb_load_en),
    .wb_in_weight (wb_in_weight),
    .wb_out_en    (wb_out_en),
    .drain_req    (drain_req),
    .weights_ready(weights_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // SRAM returns garbage when not read so zeroing of wb_in_weight is visible.
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 32'hDEADBEEF;

  // Expected outputs at cycle k after start sampled at edge 0; d = drain edge, rk = reset edge (-1: none).
  function automatic obs_t model(int k, logic [9:0] base, int nreal, int d, int rk);
    obs_t e;
    logic [9:0] a;
    e = '0;
    if (rk >= 0 && k > rk) return e;
    if (k >= 1 && k <= nreal) begin
      e.rd   = 1'b1;
      e.addr = base + 10'(k - 1);
    end
    if (k >= 2 && k <= 5) begin
      e.load = 1'b1;
      if (k - 2 < nreal) begin
        a = base + 10'(k - 2);
        e.wdata = mem[a];
      end
    end
    e.ready = (k >= 6) && (d < 0 || k <= d);
    e.out   = (d >= 0) && (k > d) && (k <= d + 4);
    e.done  = (d >= 0) && (k == d + 5);
    e.busy  = (k >= 1) && (d < 0 || k <= d + 5);
    return e;
  endfunction

  task automatic clear_stim();
    for (int k = 0; k < NCYC; k++) begin
      st_start[k] = 1'b0;
      st_drain[k] = 1'b0;
      st_rst[k]   = 1'b0;
    end
  endtask

  // Sample outputs mid-cycle, then apply that cycle's stimulus for the next rising edge.
  task automatic run();
    for (int k = 0; k < NCYC; k++) begin
      @(negedge clk);
      cap[k].rd    = mem_rd_en;
      cap[k].addr  = mem_rd_en ? mem_addr : 10'd0;
      cap[k].load  = wb_load_en;
      cap[k].wdata = wb_in_weight;
      cap[k].ready = weights_ready;
      cap[k].out   = wb_out_en;
      cap[k].done  = done;
      cap[k].busy  = busy;
      start     = st_start[k];
      drain_req = st_drain[k];
      rst       = st_rst[k];
    end
    @(negedge clk);
    start = 1'b0; drain_req = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    o = '{rd: mem_rd_en, addr: mem_addr, load: wb_load_en, wdata: wb_in_weight,
          ready: weights_ready, out: wb_out_en, done: done, busy: busy};
    n_checks++;
    if (o !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=0", o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    obs_t e;
    clear_stim();
    base_addr = 10'h010; num_rows = 3'd4;
    st_start[0] = 1'b1;
    st_drain[9] = 1'b1;
    run();
    for (int k = 0; k < NCYC; k++) begin
      e = model(k, 10'h010, 4, 9, -1);
      n_checks++;
      if (cap[k] !== e) begin
        n_fail++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", k, cap[k], e);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t e;
    clear_stim();
    base_addr = 10'h3FE; num_rows = 3'd4;
    st_start[0] = 1'b1;
    st_drain[7] = 1'b1;
    run();
    for (int k = 0; k < NCYC; k++) begin
      e = model(k, 10'h3FE, 4, 7, -1);
      n_checks++;
      if (cap[k] !== e) begin
        n_fail++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", k, cap[k], e);
      end
    end
  endtask

  task automatic test_ignore();
    obs_t e;
    clear_stim();
    base_addr = 10'h010; num_rows = 3'd4;
    st_start[0]  = 1'b1;
    st_start[2]  = 1'b1;
    st_drain[3]  = 1'b1;
    st_drain[9]  = 1'b1;
    st_start[14] = 1'b1;
    run();
    for (int k = 0; k < NCYC; k++) begin
      e = model(k, 10'h010, 4, 9, -1);
      n_checks++;
      if (cap[k] !== e) begin
        n_fail++;
        $display("FAIL ignore cyc=%0d got=%h exp=%h", k, cap[k], e);
      end
    end
  endtask

  task automatic test_early_drain();
    obs_t e;
    clear_stim();
    base_addr = 10'h020; num_rows = 3'd4;
    st_start[0] = 1'b1;
    for (int k = 0; k < NCYC; k++) st_drain[k] = 1'b1;
    run();
    for (int k = 0; k < NCYC; k++) begin
      e = model(k, 10'h020, 4, 6, -1);
      n_checks++;
      if (cap[k] !== e) begin
        n_fail++;
        $display("FAIL early_drain cyc=%0d got=%h exp=%h", k, cap[k], e);
      end
    end
  endtask

  task automatic test_reset_midflight();
    obs_t e;
    clear_stim();
    base_addr = 10'h010; num_rows = 3'd4;
    st_start[0] = 1'b1;
    st_rst[3]   = 1'b1;
    run();
    for (int k = 0; k < NCYC; k++) begin
      e = model(k, 10'h010, 4, -1, 3);
      n_checks++;
      if (cap[k] !== e) begin
        n_fail++;
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h", k, cap[k], e);
      end
    end
  endtask

  task automatic test_zpad(input logic [2:0] rows, input int nreal_zpad);
    obs_t e;
    int   nreal;
`ifdef WEIGHT_LOADER_ZPAD_EN
    nreal = nreal_zpad;
`else
    nreal = 4;
`endif
    clear_stim();
    base_addr = 10'h010; num_rows = rows;
    st_start[0] = 1'b1;
    st_drain[8] = 1'b1;
    run();
    for (int k = 0; k < NCYC; k++) begin
      e = model(k, 10'h010, nreal, 8, -1);
      n_checks++;
      if (cap[k] !== e) begin
        n_fail++;
        $display("FAIL zpad rows=%0d cyc=%0d got=%h exp=%h", rows, k, cap[k], e);
      end
    end
    num_rows = 3'd4;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5000000 | 32'(i);
    mem[10'h010] = 32'h11223344;
    mem[10'h011] = 32'h55667788;
    mem[10'h012] = 32'h99AABBCC;
    mem[10'h013] = 32'hDDEEFF00;
    clear_stim();
    test_reset();
    test_basic();
    test_wrap();
    test_ignore();
    test_early_drain();
    test_reset_midflight();
    test_basic();
    test_zpad(3'd2, 2);
    test_zpad(3'd0, 4);
    test_zpad(3'd7, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
